// File: rtl/uzorak_loader_if.sv
// Bus between the feature-word source, the sample loader and the network input.
// The slave modport is the loader side. The master modport is the producer/consumer side.
interface uzorak_loader_if #(
   parameter int N_FEAT = 60,
   parameter int W      = 16
);
   logic                  start;
   logic                  abort;
   logic [W-1:0]          in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [N_FEAT*W-1:0]   uzorak;
   logic                  uzorak_valid;
   logic                  uzorak_ack;
   logic                  busy;
   logic [5:0]            word_count;
   logic                  restart_err;

   // Word handshake: a word moves on any cycle where in_valid && in_ready.
   // in_ready depends only on loader state and never on in_valid.
   modport slave (
      input  start, abort, in_data, in_valid, uzorak_ack,
      output in_ready, uzorak, uzorak_valid, busy, word_count, restart_err
   );

   modport master (
      output start, abort, in_data, in_valid, uzorak_ack,
      input  in_ready, uzorak, uzorak_valid, busy, word_count, restart_err
   );
endinterface

// File: rtl/uzorak_loader.sv
// Assembles N_FEAT words of W bits into one sample for the network input.
// Words are stored MSB-first. The sample is held until the consumer acknowledges it.
module uzorak_loader #(
   parameter int N_FEAT = 60,
   parameter int W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   uzorak_loader_if.slave   bus,
   output logic [1:0]       state_dbg
);
   localparam int NW = N_FEAT * W;
   localparam int CW = 6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [NW-1:0]   shadow_q, shadow_d;
   logic [NW-1:0]   uzorak_q, uzorak_d;
   logic            valid_q, valid_d;
   logic            rerr_q, rerr_d;
   logic [CW-1:0]   wc_q, wc_d;

   logic            accept;
   logic            last_word;
   logic [NW-1:0]   shifted;

   assign accept    = bus.in_valid && (state_q == S_LOAD);
   assign last_word = (wc_q == CW'(N_FEAT - 1));
   assign shifted   = {shadow_q[NW-W-1:0], bus.in_data};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         shadow_q <= '0;
         uzorak_q <= '0;
         valid_q  <= 1'b0;
         rerr_q   <= 1'b0;
         wc_q     <= '0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         uzorak_q <= uzorak_d;
         valid_q  <= valid_d;
         rerr_q   <= rerr_d;
         wc_q     <= wc_d;
      end
   end

   // Priority inside LOAD is abort, then restart, then word accept.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      uzorak_d = uzorak_q;
      valid_d  = valid_q;
      rerr_d   = rerr_q;
      wc_d     = wc_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d  = S_LOAD;
               shadow_d = '0;
               wc_d     = '0;
            end
         end
         S_LOAD: begin
            if (bus.abort) begin
               state_d = S_IDLE;
               wc_d    = '0;
            end else if (bus.start) begin
               shadow_d = '0;
               wc_d     = '0;
               rerr_d   = 1'b1;
            end else if (accept) begin
               shadow_d = shifted;
               if (last_word) begin
                  uzorak_d = shifted;
                  valid_d  = 1'b1;
                  wc_d     = '0;
                  state_d  = S_HOLD;
               end else begin
                  wc_d = wc_q + CW'(1);
               end
            end
         end
         S_HOLD: begin
            if (bus.uzorak_ack) begin
               valid_d = 1'b0;
               if (bus.start) begin
                  state_d  = S_LOAD;
                  shadow_d = '0;
                  wc_d     = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready     = (state_q == S_LOAD);
      bus.busy         = (state_q == S_LOAD);
      bus.uzorak       = uzorak_q;
      bus.uzorak_valid = valid_q;
      bus.word_count   = wc_q;
      bus.restart_err  = rerr_q;
      state_dbg        = state_q;
   end
endmodule

// File: tb/tb_uzorak_loader.sv
// Bench for uzorak_loader: directed scenarios plus a random phase.
// All outputs are checked every cycle against a word-queue model of the loader.
module tb_uzorak_loader;
   localparam int N  = 60;
   localparam int W  = 16;
   localparam int NW = N * W;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [1:0] state_dbg;

   uzorak_loader_if #(.N_FEAT(N), .W(W)) bus ();

   uzorak_loader #(.N_FEAT(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: phase 0 = waiting for start, 1 = collecting words, 2 = sample held.
   int            m_phase;
   logic [W-1:0]  m_words[$];
   logic [NW-1:0] m_uzorak;
   logic          m_valid;
   logic          m_rerr;

   task automatic check(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase  = 0;
      m_words.delete();
      m_uzorak = '0;
      m_valid  = 1'b0;
      m_rerr   = 1'b0;
   endtask

   task automatic model_clock();
      case (m_phase)
         0: if (bus.start) begin
               m_phase = 1;
               m_words.delete();
            end
         1: if (bus.abort) begin
               m_phase = 0;
               m_words.delete();
            end else if (bus.start) begin
               m_words.delete();
               m_rerr = 1'b1;
            end else if (bus.in_valid) begin
               m_words.push_back(bus.in_data);
               if (m_words.size() == N) begin
                  for (int i = 0; i < N; i++) m_uzorak[(N-1-i)*W +: W] = m_words[i];
                  m_valid = 1'b1;
                  m_phase = 2;
                  m_words.delete();
               end
            end
         2: if (bus.uzorak_ack) begin
               m_valid = 1'b0;
               m_words.delete();
               m_phase = bus.start ? 1 : 0;
            end
         default: m_phase = 0;
      endcase
   endtask

   task automatic check_all();
      check("in_ready", NW'(bus.in_ready), NW'(m_phase == 1));
      check("busy", NW'(bus.busy), NW'(m_phase == 1));
      check("uzorak_valid", NW'(bus.uzorak_valid), NW'(m_valid));
      check("word_count", NW'(bus.word_count), NW'(m_words.size()));
      check("restart_err", NW'(bus.restart_err), NW'(m_rerr));
      check("uzorak", bus.uzorak, m_uzorak);
   endtask

   task automatic step(input bit s, input bit a, input bit v, input logic [W-1:0] d, input bit k);
      @(negedge clk);
      bus.start      = s;
      bus.abort      = a;
      bus.in_valid   = v;
      bus.in_data    = d;
      bus.uzorak_ack = k;
      @(posedge clk);
      model_clock();
      #1;
      check_all();
   endtask

   // Feed n words; seq selects base+i data, toggle inserts an idle cycle before each word.
   task automatic feed(input int n, input bit seq, input int base, input bit toggle);
      for (int i = 0; i < n; i++) begin
         if (toggle) step(1'b0, 1'b0, 1'b0, W'($urandom), 1'b0);
         step(1'b0, 1'b0, 1'b1, seq ? W'(base + i) : W'($urandom), 1'b0);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0;
      bus.in_data = '0; bus.uzorak_ack = 1'b0;
      model_reset();
      #1 rst = 1'b1;
      #1 check_all();
      @(negedge clk) rst = 1'b0;

      // Back-to-back sequential load
      step(1'b1, 1'b0, 1'b1, 16'hdead, 1'b0);
      feed(N - 1, 1'b1, 1, 1'b0);
      check("pre_last_valid", NW'(bus.uzorak_valid), NW'(1'b0));
      step(1'b0, 1'b0, 1'b1, W'(N), 1'b0);
      check("msb_word", NW'(bus.uzorak[NW-1 -: W]), NW'(16'h0001));
      check("lsb_word", NW'(bus.uzorak[W-1:0]), NW'(16'h003C));
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);

      // Same data with in_valid toggling
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      feed(N, 1'b1, 1, 1'b1);
      check("toggle_msb", NW'(bus.uzorak[NW-1 -: W]), NW'(16'h0001));

      // Long hold with in_valid high, then ack
      for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b1, W'($urandom), 1'b0);
      step(1'b0, 1'b0, 1'b1, W'($urandom), 1'b1);
      check("after_ack_lsb", NW'(bus.uzorak[W-1:0]), NW'(16'h003C));

      // Abort mid-load, then restart mid-load, then full load
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      feed(20, 1'b0, 0, 1'b0);
      step(1'b0, 1'b1, 1'b1, W'($urandom), 1'b0);
      check("abort_wc", NW'(bus.word_count), NW'(0));
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      feed(20, 1'b0, 0, 1'b0);
      step(1'b1, 1'b0, 1'b1, W'($urandom), 1'b0);
      check("restart_err_set", NW'(bus.restart_err), NW'(1'b1));
      feed(N, 1'b1, 16'h100, 1'b0);
      check("restart_msb", NW'(bus.uzorak[NW-1 -: W]), NW'(16'h0100));

      // Start and ack together in HOLD
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      check("start_ack_busy", NW'(bus.busy), NW'(1'b1));
      feed(N, 1'b0, 0, 1'b0);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);

      // Random traffic
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 24) == 0, $urandom_range(0, 199) == 0,
              $urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 7) == 0);

      // Asynchronous reset between edges after 30 words
      step(1'b0, 1'b1, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      feed(30, 1'b0, 0, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 model_reset();
      check_all();
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1, W'($urandom), 1'b0);
      check("no_valid_after_rst", NW'(bus.uzorak_valid), NW'(1'b0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uzorak_loader.md
UZORAK_LOADER -- requirements
Module: uzorak_loader

Interface
REQ-001 Parameter N_FEAT, default 60: number of features per sample.
REQ-002 Parameter W, default 16: bits per feature; N_FEAT*W = 960 at defaults.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  one-cycle request to begin loading a new sample.
REQ-006 abort  in  1  synchronous cancel of a load in progress.
REQ-007 in_data  in  W  feature word.
REQ-008 in_valid  in  1  in_data valid this cycle.
REQ-009 in_ready  out  1  loader accepts a word this cycle.
REQ-010 uzorak  out  N_FEAT*W  assembled sample driven to the neural net input.
REQ-011 uzorak_valid  out  1  uzorak holds a complete new sample.
REQ-012 uzorak_ack  in  1  consumer has latched the network result; releases the sample.
REQ-013 busy  out  1  high in LOAD.
REQ-014 word_count  out  6  words accepted in the current load.
REQ-015 restart_err  out  1  sticky flag: start seen during LOAD.

Function
REQ-016 States: IDLE, LOAD, HOLD; encoding is free.
REQ-017 Accept = in_valid && in_ready; in_ready is 1 only in LOAD; in_ready is combinational from state only, never from in_valid.
REQ-018 IDLE: start -> LOAD next cycle, shadow register and word_count cleared; in_valid ignored.
REQ-019 LOAD: on each accept, shadow = {shadow[N_FEAT*W-W-1:0], in_data}, word_count += 1.
REQ-020 Word order: the first accepted word ends in uzorak[N_FEAT*W-1 -: W], the last in uzorak[W-1:0], i.e. MSB-first, matching hex-literal sample order.
REQ-021 On the accept that brings word_count to N_FEAT: next cycle uzorak = full shadow, uzorak_valid = 1, state HOLD, word_count = 0; latency from last accept to uzorak_valid is exactly 1 cycle.
REQ-022 uzorak changes only on the REQ-021 transfer; it is stable throughout LOAD and HOLD and after abort.
REQ-023 HOLD: uzorak_valid held 1 until uzorak_ack; on ack -> IDLE next cycle with uzorak_valid = 0, uzorak retained.
REQ-024 HOLD with start and uzorak_ack in the same cycle -> LOAD directly, uzorak_valid = 0, shadow and word_count cleared.
REQ-025 HOLD with start and no ack: start ignored, no flag.
REQ-026 LOAD with start: load restarts (shadow and word_count cleared, stay in LOAD), restart_err set; any word accepted that same cycle is discarded.
REQ-027 LOAD with abort: -> IDLE next cycle, word_count = 0, uzorak and uzorak_valid unchanged; abort overrides start and any accept in the same cycle.
REQ-028 abort in IDLE or HOLD: no effect.
REQ-029 uzorak_ack outside HOLD: ignored.
REQ-030 restart_err clears only on reset.
REQ-031 word_count never exceeds N_FEAT-1 as a visible value; no wrap-around beyond N_FEAT.

Reset
REQ-032 rst high: state IDLE, uzorak = 0, shadow = 0, uzorak_valid = 0, in_ready = 0, busy = 0, word_count = 0, restart_err = 0, immediately and without clock.
REQ-033 rst asserted mid-LOAD or in HOLD discards all progress; first legal action after release is start.

Verification
REQ-034 start, then 60 words 16'h0001..16'h003C back-to-back -> uzorak_valid 1 cycle after 60th accept; uzorak[959:944] = 16'h0001, uzorak[15:0] = 16'h003C.
REQ-035 Same load with in_valid toggling 1/0 every cycle -> 120 cycles of LOAD, identical uzorak, word_count steps only on accepts.
REQ-036 Complete load, hold uzorak_ack 0 for 50 cycles while driving in_valid=1 -> in_ready 0, uzorak and uzorak_valid unchanged; ack -> IDLE, uzorak retained.
REQ-037 start, 20 words, abort -> IDLE, word_count 0, uzorak still previous sample; then start, 20 words, start -> restart_err 1, word_count 0, full load of 60 words yields only post-restart data.
REQ-038 In HOLD, start and uzorak_ack together -> LOAD next cycle, uzorak_valid 0, restart_err unchanged.
REQ-039 rst pulse between clock edges after 30 words -> all outputs at REQ-032 values before next edge; no uzorak_valid afterwards without a new start.
